// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared debounce constants, state encodings and helpers
package button_debounce_pkg;

    localparam int DB_STABLE_CYCLES = 500000;
    localparam int DB_CNT_W         = 19;

    typedef logic [1:0] db_state_t;

    localparam logic [1:0] ST_IDLE_LOW  = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
    localparam logic [1:0] ST_IDLE_HIGH = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button debouncer with rise pulse and glitch counter
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
    parameter int CNT_W         = DB_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_out,
    output logic       btn_rise,
    output logic [7:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_q;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (sync_q)
    );

    // Entry into a WAIT state counts as the first stable cycle, so acceptance
    // lands STABLE_CYCLES edges after entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE_LOW;
            cnt        <= '0;
            btn_out    <= 1'b0;
            btn_rise   <= 1'b0;
            glitch_cnt <= 8'd0;
        end else begin
            btn_rise <= 1'b0;
            case (state)
                ST_IDLE_LOW: begin
                    if (sync_q) begin
                        state <= ST_WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!sync_q) begin
                        state      <= ST_IDLE_LOW;
                        glitch_cnt <= sat_inc8(glitch_cnt);
                    end else if (cnt == CNT_LAST) begin
                        state    <= ST_IDLE_HIGH;
                        btn_out  <= 1'b1;
                        btn_rise <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_IDLE_HIGH: begin
                    if (!sync_q) begin
                        state <= ST_WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                ST_WAIT_LOW: begin
                    if (sync_q) begin
                        state      <= ST_IDLE_HIGH;
                        glitch_cnt <= sat_inc8(glitch_cnt);
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_IDLE_LOW;
                        btn_out <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - scoreboard bench for button_debounce against a run-length model
module tb_button_debounce;

    localparam int SC = 4;
    localparam int CW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       btn_out;
    logic       btn_rise;
    logic [7:0] glitch_cnt;

    always #5 clk = ~clk;

    button_debounce #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_out    (btn_out),
        .btn_rise   (btn_rise),
        .glitch_cnt (glitch_cnt)
    );

    typedef struct {
        logic       out;
        logic       rise;
        logic [7:0] gl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference: accepted level plus length of the current run of opposite
    // samples as seen two edges late through the synchronizer.
    logic m_level = 1'b0;
    logic m_p1 = 1'b0;
    logic m_p2 = 1'b0;
    int   m_run = 0;
    int   m_gl = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    task automatic step(input logic b, input logic r);
        exp_t e;
        logic seen;
        @(negedge clk);
        btn_in = b;
        rst    = r;
        e.rise = 1'b0;
        if (r) begin
            m_level = 1'b0; m_p1 = 1'b0; m_p2 = 1'b0; m_run = 0; m_gl = 0;
        end else begin
            seen = m_p2;
            m_p2 = m_p1;
            m_p1 = b;
            if (seen != m_level) begin
                m_run++;
                if (m_run == SC + 1) begin
                    m_level = seen;
                    e.rise  = seen;
                    m_run   = 0;
                end
            end else begin
                if (m_run > 0 && m_gl < 255) m_gl++;
                m_run = 0;
            end
        end
        e.out = m_level;
        e.gl  = 8'(m_gl);
        exp_q.push_back(e);
        if (r) begin
            #1;
            check("rst_out_now", int'(btn_out), 0);
            check("rst_rise_now", int'(btn_rise), 0);
            check("rst_glitch_now", int'(glitch_cnt), 0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("btn_out", int'(btn_out), int'(e.out));
                check("btn_rise", int'(btn_rise), int'(e.rise));
                check("glitch_cnt", int'(glitch_cnt), int'(e.gl));
            end
        end
    end

    initial begin : driver
        int  len;
        logic lvl;
        repeat (3) step(1'b0, 1'b1);
        // clean press, release, short bounce
        repeat (20) step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0);
        repeat (2)  step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        // reset while waiting for a high level to settle
        repeat (5)  step(1'b1, 1'b0);
        repeat (2)  step(1'b1, 1'b1);
        repeat (15) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);
        // random runs with occasional reset
        for (int i = 0; i < 400; i++) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            for (int j = 0; j < len; j++)
                step(lvl, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        // glitch counter saturation
        step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            repeat (2) step(1'b1, 1'b0);
            repeat (2) step(1'b0, 1'b0);
        end
        repeat (10) step(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("glitch_saturated", int'(glitch_cnt), 255);
        check("btn_out_after_bounces", int'(btn_out), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
